// File: rtl/noc_pkg.sv
// Shared NoC harness definitions: opcodes, command/flit field positions and default widths.
package noc_pkg;

    // Default widths
    localparam int unsigned NOC_OP_W   = 4;
    localparam int unsigned NOC_DATA_W = 16;
    localparam int unsigned NOC_BUF_W  = 13;
    localparam int unsigned NOC_DST_W  = 4;
    localparam int unsigned NOC_VC_W   = 2;
    localparam int unsigned NOC_NF_W   = 4;
    localparam int unsigned NOC_TOT_W  = 8;
    localparam int unsigned NOC_DEPTH  = 16;

    // Harness opcodes (shared with the router)
    localparam int unsigned NOP     = 0;
    localparam int unsigned INIT    = 1;
    localparam int unsigned FILL    = 8;
    localparam int unsigned DEQUEUE = 9;

    // FILL operand field positions
    localparam int unsigned FILL_DST_LSB = 0;
    localparam int unsigned FILL_VC_LSB  = 4;
    localparam int unsigned FILL_NF_LSB  = 6;

    // Flit field positions
    localparam int unsigned FLIT_VALID_BIT = 0;
    localparam int unsigned FLIT_HEAD_BIT  = 1;
    localparam int unsigned FLIT_TAIL_BIT  = 2;
    localparam int unsigned FLIT_VC_LSB    = 3;
    localparam int unsigned FLIT_DST_LSB   = 5;
    localparam int unsigned FLIT_SEQ_LSB   = 9;

endpackage

// File: rtl/desc_fifo.sv
// Synchronous descriptor FIFO with occupancy-count full/empty and a synchronous clear.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module desc_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    // Status and gated strobes
    always_comb begin
        full_c    = (count == CW'(DEPTH));
        empty_c   = (count == '0);
        do_wr     = wr_en & ~full_c;
        do_rd     = rd_en & ~empty_c;
        rd_data_c = mem[rd_ptr];
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + CW'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/traffic_injector.sv
// Per-node packet source: queues packet descriptors and presents one flit at a time on buffer.
// Optional feature macro: TRAFFIC_INJECTOR_STATS_EN adds a 16-bit flit_count output.
module traffic_injector
    import noc_pkg::*;
#(
    parameter int unsigned OP_W   = NOC_OP_W,
    parameter int unsigned DATA_W = NOC_DATA_W,
    parameter int unsigned BUF_W  = NOC_BUF_W,
    parameter int unsigned DST_W  = NOC_DST_W,
    parameter int unsigned VC_W   = NOC_VC_W,
    parameter int unsigned NF_W   = NOC_NF_W,
    parameter int unsigned TOT_W  = NOC_TOT_W,
    parameter int unsigned DEPTH  = NOC_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] data,
    output logic              done,
    output logic [BUF_W-1:0]  buffer
`ifdef TRAFFIC_INJECTOR_STATS_EN
    ,
    output logic [15:0]       flit_count
`endif
);

    localparam int unsigned DESC_W = NF_W + VC_W + DST_W;

    logic              is_init;
    logic              is_fill;
    logic              is_deq;
    logic [NF_W-1:0]   fill_nf;
    logic [NF_W-1:0]   fill_nf_adj;
    logic [DESC_W-1:0] fill_desc;
    logic [DESC_W-1:0] head_desc;
    logic [NF_W-1:0]   head_nf;
    logic [VC_W-1:0]   head_vc;
    logic [DST_W-1:0]  head_dst;
    logic              q_full;
    logic              q_empty;
    logic              at_tail;
    logic              pop;
    logic              deq_valid;
    logic [NF_W-1:0]   seq;
    logic [TOT_W-1:0]  remaining;
    logic              inited;
    logic              unused_data;

    // Opcode decode; unknown opcodes fall through as NOP
    always_comb begin
        is_init = 1'b0;
        is_fill = 1'b0;
        is_deq  = 1'b0;
        case (op)
            OP_W'(INIT):    is_init = 1'b1;
            OP_W'(FILL):    is_fill = 1'b1;
            OP_W'(DEQUEUE): is_deq  = 1'b1;
            OP_W'(NOP):     ;
            default:        ;
        endcase
    end

    // Descriptor formatting and head flit bookkeeping; a zero flit count means one flit
    always_comb begin
        fill_nf     = data[FILL_NF_LSB +: NF_W];
        fill_nf_adj = (fill_nf == '0) ? NF_W'(1) : fill_nf;
        fill_desc   = {fill_nf_adj, data[FILL_VC_LSB +: VC_W], data[FILL_DST_LSB +: DST_W]};
        {head_nf, head_vc, head_dst} = head_desc;
        at_tail     = (seq == head_nf - NF_W'(1));
        deq_valid   = is_deq & ~q_empty;
        pop         = deq_valid & at_tail;
        unused_data = ^data;
    end

    desc_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (DEPTH)
    ) u_desc_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (is_init),
        .wr_en     (is_fill),
        .wr_data   (fill_desc),
        .rd_en     (pop),
        .rd_data_c (head_desc),
        .full_c    (q_full),
        .empty_c   (q_empty)
    );

    // Head flit presented straight from the queue head and seq; all zero when empty
    always_comb begin
        buffer = '0;
        if (!q_empty) begin
            buffer[FLIT_VALID_BIT]             = 1'b1;
            buffer[FLIT_HEAD_BIT]              = (seq == '0);
            buffer[FLIT_TAIL_BIT]              = at_tail;
            buffer[FLIT_VC_LSB +: VC_W]        = head_vc;
            buffer[FLIT_DST_LSB +: DST_W]      = head_dst;
            buffer[FLIT_SEQ_LSB +: NF_W]       = seq;
        end
    end

    // Flit index within the current head packet
    always_ff @(posedge clk) begin
        if (rst || is_init) begin
            seq <= '0;
        end else if (deq_valid) begin
            seq <= at_tail ? '0 : seq + NF_W'(1);
        end
    end

    // Packets still to be loaded; only accepted FILLs count down, saturating at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            inited    <= 1'b0;
        end else if (is_init) begin
            remaining <= data[TOT_W-1:0];
            inited    <= 1'b1;
        end else if (is_fill && !q_full && (remaining != '0)) begin
            remaining <= remaining - TOT_W'(1);
        end
    end

    // Completion flag, registered one cycle behind the state that satisfies it
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= inited & (remaining == '0) & q_empty;
        end
    end

`ifdef TRAFFIC_INJECTOR_STATS_EN
    // Count of flits handed to the router, wrapping at 2^16
    always_ff @(posedge clk) begin
        if (rst || is_init) begin
            flit_count <= '0;
        end else if (deq_valid) begin
            flit_count <= flit_count + 16'(1);
        end
    end
`endif

endmodule

// File: tb/tb_traffic_injector.sv
// Scoreboard bench for traffic_injector: FILLs push expected flits, a monitor checks each dequeued flit.
module tb_traffic_injector;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_INIT = 4'd1;
    localparam logic [3:0] OP_FILL = 4'd8;
    localparam logic [3:0] OP_DEQ = 4'd9;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  op;
    logic [15:0] data;
    logic        done;
    logic [12:0] buffer;
`ifdef TRAFFIC_INJECTOR_STATS_EN
    logic [15:0] flit_count;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [12:0] exp_q [$];

    traffic_injector dut (
        .clk    (clk),
        .rst    (rst),
        .op     (op),
        .data   (data),
        .done   (done),
        .buffer (buffer)
`ifdef TRAFFIC_INJECTOR_STATS_EN
        ,
        .flit_count (flit_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    endtask

    function automatic logic [12:0] mkflit(input logic h, input logic t, input logic [1:0] vc,
                                           input logic [3:0] dst, input logic [3:0] seq);
        return {seq, dst, vc, t, h, 1'b1};
    endfunction

    // Apply one op for exactly one clock edge; INIT discards whatever the scoreboard expected
    task automatic issue(input logic [3:0] o, input logic [15:0] d);
        op = o;
        data = d;
        @(posedge clk);
        #2;
        op = OP_NOP;
        data = '0;
        if (o == OP_INIT) exp_q.delete();
    endtask

    task automatic fill(input logic [3:0] dst, input logic [1:0] vc, input logic [3:0] nf, input bit push);
        logic [3:0] eff;
        issue(OP_FILL, {6'd0, nf, vc, dst});
        eff = (nf == 4'd0) ? 4'd1 : nf;
        if (push) begin
            for (int s = 0; s < int'(eff); s++)
                exp_q.push_back(mkflit(s == 0, s == int'(eff) - 1, vc, dst, 4'(s)));
        end
    endtask

    // Dequeue until the head goes invalid, bounded
    task automatic drain(input string name);
        int n = 0;
        while (buffer[0] && n < 200) begin
            issue(OP_DEQ, '0);
            n++;
        end
        if (buffer[0]) check({name, "_timeout"}, 32'(n), 32'd0);
    endtask

    // Monitor: the flit consumed by each pending DEQUEUE must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && op == OP_DEQ && buffer[0]) begin
            if (exp_q.size() == 0) begin
                check("flit_unexpected", 32'(buffer), 32'h0);
            end else begin
                check("flit", 32'(buffer), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        op = OP_DEQ;
        data = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        check("reset_buffer", 32'(buffer), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        @(posedge clk);
        #2;
        check("idle_deq_buffer", 32'(buffer), 32'h0);
        check("idle_deq_done", 32'(done), 32'h0);
`ifdef TRAFFIC_INJECTOR_STATS_EN
        check("idle_flit_count", 32'(flit_count), 32'h0);
`endif
        op = OP_NOP;

        // Three-flit packet dst=5 vc=2
        issue(OP_INIT, 16'd1);
        fill(4'd5, 2'd2, 4'd3, 1'b1);
        check("fill_visible", 32'(buffer), 32'h0B3);
        issue(OP_DEQ, '0);
        check("seq1_view", 32'(buffer), 32'h2B1);
        issue(OP_DEQ, '0);
        check("seq2_view", 32'(buffer), 32'h4B5);
        issue(OP_NOP, '0);
        check("done_mid_pkt", 32'(done), 32'h0);
        issue(OP_DEQ, '0);
        check("pkt1_empty", 32'(buffer), 32'h0);
        issue(OP_NOP, '0);
        check("done_pkt1", 32'(done), 32'h1);

        // Single-flit packets, including num_flit=0
        issue(OP_INIT, 16'd2);
        fill(4'd3, 2'd1, 4'd1, 1'b1);
        fill(4'd7, 2'd0, 4'd0, 1'b1);
        check("nf1_view", 32'(buffer), 32'h06F);
        issue(OP_DEQ, '0);
        check("nf0_view", 32'(buffer), 32'h0E7);
        issue(OP_NOP, '0);
        check("done_after_first_single", 32'(done), 32'h0);
        issue(OP_DEQ, '0);
        issue(OP_NOP, '0);
        check("done_singles", 32'(done), 32'h1);

        // Overfill: 17th FILL is dropped and remaining stays at 4
        issue(OP_INIT, 16'd20);
        for (int i = 0; i < 17; i++)
            fill(4'(i), 2'(i), 4'((i % 3) + 1), i < 16);
        drain("drain16");
        issue(OP_NOP, '0);
        check("done_after_16", 32'(done), 32'h0);
        for (int i = 0; i < 3; i++) fill(4'(i + 4), 2'(i), 4'd2, 1'b1);
        drain("drain3");
        issue(OP_NOP, '0);
        check("done_remaining1", 32'(done), 32'h0);
        fill(4'd15, 2'd3, 4'd1, 1'b1);
        drain("drain1");
        issue(OP_NOP, '0);
        check("done_remaining0", 32'(done), 32'h1);

        // INIT mid-packet discards pending flits
        issue(OP_INIT, 16'd1);
        fill(4'd9, 2'd3, 4'd4, 1'b1);
        issue(OP_DEQ, '0);
        check("mid_pkt_view", 32'(buffer), 32'h339);
        issue(OP_INIT, 16'd0);
        check("init_flush_buffer", 32'(buffer), 32'h0);
        issue(OP_NOP, '0);
        check("init_zero_done", 32'(done), 32'h1);

        // Five valid dequeues plus two on an empty queue
        issue(OP_INIT, 16'd2);
`ifdef TRAFFIC_INJECTOR_STATS_EN
        check("stats_cleared", 32'(flit_count), 32'h0);
`endif
        fill(4'd2, 2'd1, 4'd3, 1'b1);
        fill(4'd4, 2'd0, 4'd2, 1'b1);
        repeat (5) issue(OP_DEQ, '0);
        repeat (2) issue(OP_DEQ, '0);
        check("stats_empty", 32'(buffer), 32'h0);
        issue(OP_NOP, '0);
        check("stats_done", 32'(done), 32'h1);
`ifdef TRAFFIC_INJECTOR_STATS_EN
        check("flit_count", 32'(flit_count), 32'd5);
`endif

        check("scoreboard_left", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
